// File: rtl/bf_result_checker_if.sv
// Mismatch record stream for the Bellman-Ford result checker.
// The checker drives a record and the consumer returns ready.
interface bf_result_checker_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              err_valid;
  logic              err_ready;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_got;
  logic [DATA_W-1:0] err_exp;

  modport master (
    output err_valid,
    output err_addr,
    output err_got,
    output err_exp,
    input  err_ready
  );

  modport slave (
    input  err_valid,
    input  err_addr,
    input  err_got,
    input  err_exp,
    output err_ready
  );
endinterface

// File: rtl/bf_result_checker.sv
// Scans the Bellman-Ford output memory against an expected memory,
// counts mismatches and INF entries, streams mismatch records.
module bf_result_checker #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 13,
  parameter int                DEPTH      = 8192,
  parameter logic [DATA_W-1:0] INF        = {DATA_W{1'b1}},
  parameter bit                ERR_STREAM = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                neg_cycle,
  input  logic                expect_neg,
  output logic [ADDR_W-1:0]   OMAR,
  input  logic [DATA_W-1:0]   OMDR,
  output logic [ADDR_W-1:0]   EMAR,
  input  logic [DATA_W-1:0]   EMDR,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                neg_seen,
  output logic [ADDR_W:0]     mismatch_count,
  output logic [ADDR_W:0]     unreach_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  bf_result_checker_if.master err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ERRWAIT,
    S_NEGCHK,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_mis;
  logic [ADDR_W:0]   r_unr;
  logic [ADDR_W-1:0] r_first;
  logic              r_pass;
  logic              r_neg_seen;
  logic              r_err_valid;
  logic              r_err_last;
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_got;
  logic [DATA_W-1:0] r_err_exp;

  logic            w_mis;
  logic            w_inf;
  logic            w_last;
  logic            w_launch;
  logic            w_stall;
  logic            w_accept;
  logic [ADDR_W:0] w_mis_next;

  assign w_mis      = (OMDR != EMDR);
  assign w_inf      = (OMDR == INF);
  assign w_last     = (r_addr == LAST);
  assign w_launch   = start | neg_cycle;
  assign w_stall    = w_mis && ERR_STREAM;
  assign w_accept   = r_err_valid && err.err_ready;
  assign w_mis_next = r_mis + {{ADDR_W{1'b0}}, w_mis};

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode; neg_cycle always wins over scan progress
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (neg_cycle) begin
          w_next = S_NEGCHK;
        end else if (start) begin
          w_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (neg_cycle) begin
          w_next = S_NEGCHK;
        end else if (w_stall) begin
          w_next = S_ERRWAIT;
        end else if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_ERRWAIT: begin
        if (neg_cycle) begin
          w_next = S_NEGCHK;
        end else if (w_accept) begin
          w_next = r_err_last ? S_DONE : S_SCAN;
        end
      end
      S_NEGCHK: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // scan datapath: address walk, counters, verdict and error record
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_mis       <= '0;
      r_unr       <= '0;
      r_first     <= '0;
      r_pass      <= 1'b0;
      r_neg_seen  <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_last  <= 1'b0;
      r_err_addr  <= '0;
      r_err_got   <= '0;
      r_err_exp   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_addr     <= '0;
            r_mis      <= '0;
            r_unr      <= '0;
            r_first    <= '0;
            r_pass     <= 1'b0;
            r_neg_seen <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!neg_cycle) begin
            if (w_inf) begin
              r_unr <= r_unr + CNT_ONE;
            end
            if (w_mis) begin
              r_mis <= w_mis_next;
              if (r_mis == '0) begin
                r_first <= r_addr;
              end
            end
            if (w_stall) begin
              r_err_valid <= 1'b1;
              r_err_last  <= w_last;
              r_err_addr  <= r_addr;
              r_err_got   <= OMDR;
              r_err_exp   <= EMDR;
            end
            // the last entry keeps its address; DONE follows directly
            // or after its record is taken
            if (!w_last) begin
              r_addr <= r_addr + 1'b1;
            end else if (!w_stall) begin
              r_pass <= (w_mis_next == '0) && !expect_neg;
            end
          end
        end
        S_ERRWAIT: begin
          if (neg_cycle) begin
            r_err_valid <= 1'b0;
          end else if (w_accept) begin
            r_err_valid <= 1'b0;
            if (r_err_last) begin
              r_pass <= (r_mis == '0) && !expect_neg;
            end
          end
        end
        S_NEGCHK: begin
          r_neg_seen <= 1'b1;
          r_pass     <= expect_neg;
          r_mis      <= expect_neg ? '0 : CNT_ONE;
        end
        default: begin
          r_err_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OMAR           = r_addr;
  assign EMAR           = r_addr;
  assign busy           = (r_state == S_SCAN) || (r_state == S_ERRWAIT);
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign neg_seen       = r_neg_seen;
  assign mismatch_count = r_mis;
  assign unreach_count  = r_unr;
  assign first_err_addr = r_first;

  assign err.err_valid  = r_err_valid;
  assign err.err_addr   = r_err_addr;
  assign err.err_got    = r_err_got;
  assign err.err_exp    = r_err_exp;

endmodule
